dbus_word_rx: RTL

Receiving end of the 4-bit DBUS[4:1] nibble bus driven by sub-blocks such as `a_sub`. Samples strobed nibbles and assembles them into a 4*NIB-bit word, least-significant nibble first. Presents each completed word on a registered valid/ready output port. Sits between the nibble-bus sources and the word-wide Q[15:0] consumers, with sticky framing and overflow flags for debug.

---
 rtl/dbus_pkg.sv | 19 +
 rtl/dbus_nib_shift.sv | 27 ++
 rtl/dbus_word_rx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared constants, state encoding and sizing helper for the DBUS nibble receiver.
package dbus_pkg;

    localparam int unsigned DBUS_W = 4;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    // Bits needed to hold a nibble count of 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/dbus_nib_shift.sv
// NIB-slot nibble assembly register; one slot written per strobe, selected by index.
module dbus_nib_shift
    import dbus_pkg::*;
#(
    parameter int unsigned NIB = 4,
    parameter int unsigned CW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [CW-1:0]         slot,
    input  logic [DBUS_W-1:0]     dbus,
    output logic [DBUS_W*NIB-1:0] word
);

    // Write the strobed nibble into the addressed slot; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else if (we) begin
            for (int unsigned k = 0; k < NIB; k++) begin
                if (slot == CW'(k)) word[DBUS_W*k +: DBUS_W] <= dbus;
            end
        end
    end

endmodule

// File: rtl/dbus_word_rx.sv
// DBUS nibble-to-word receiver: framing FSM, nibble count, registered valid/ready output, sticky flags.
module dbus_word_rx
    import dbus_pkg::*;
#(
    parameter int unsigned NIB = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DBUS_W:1]       DBUS,
    input  logic                  D,
    input  logic                  SOF,
    output logic [DBUS_W*NIB-1:0] Q,
    output logic                  QV,
    input  logic                  QR,
    input  logic                  CLR,
    output logic                  FRM,
    output logic                  OVF
);

    localparam int unsigned WW = DBUS_W * NIB;
    localparam int unsigned CW = cnt_width(NIB);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WW-1:0]   q_nxt;
    logic            of, of_nxt;
    logic            frm_nxt, ovf_nxt;
    logic            we;
    logic [CW-1:0]   slot;
    logic            complete;
    logic            frm_set, ovf_set;
    logic [WW-1:0]   asm_word;
    logic [WW-1:0]   word;

    dbus_nib_shift #(
        .NIB (NIB),
        .CW  (CW)
    ) u_shift (
        .clk  (CLK),
        .rst  (RST),
        .we   (we),
        .slot (slot),
        .dbus (DBUS),
        .word (asm_word)
    );

    // The completing nibble is merged in combinationally so Q loads on the same edge it is sampled.
    always_comb begin
        word = asm_word;
        for (int unsigned k = 0; k < NIB; k++) begin
            if (cnt == CW'(k)) word[DBUS_W*k +: DBUS_W] = DBUS;
        end
    end

    // Next-state: framing, nibble count, output register handoff and sticky flag updates.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = Q;
        of_nxt    = of;
        we        = 1'b0;
        slot      = cnt;
        complete  = 1'b0;
        frm_set   = 1'b0;
        ovf_set   = 1'b0;

        if (D) begin
            if (SOF) begin
                we        = 1'b1;
                slot      = '0;
                cnt_nxt   = CW'(1);
                state_nxt = COLLECT;
                if (state == COLLECT) frm_set = 1'b1;
            end else if (state == IDLE) begin
                frm_set = 1'b1;
            end else begin
                we = 1'b1;
                if (cnt == CW'(NIB - 1)) begin
                    complete  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end

        if (complete) begin
            if (!of || QR) begin
                q_nxt  = word;
                of_nxt = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (of && QR) begin
            of_nxt = 1'b0;
        end

        frm_nxt = frm_set ? 1'b1 : (CLR ? 1'b0 : FRM);
        ovf_nxt = ovf_set ? 1'b1 : (CLR ? 1'b0 : OVF);
    end

    // State, count, output and flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            Q     <= '0;
            of    <= 1'b0;
            FRM   <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Q     <= q_nxt;
            of    <= of_nxt;
            FRM   <= frm_nxt;
            OVF   <= ovf_nxt;
        end
    end

    assign QV = of;

endmodule
